// File: rtl/obstacle_spawner.sv
// Decides when the next cactus may spawn and which sprite it uses; gap = level-scaled minimum + LFSR extra.
// Latency: spawn_o rises 1 clk after the gap-completing frame, falls 1 clk after the accepting frame; held while the cactus stage is busy.
module obstacle_spawner #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [7:0]  MIN_GAP    = 8'd40,
    parameter logic [7:0]  LEVEL_STEP = 8'd8,
    parameter logic [7:0]  GAP_FLOOR  = 8'd16,
    parameter logic [7:0]  GAP_MASK   = 8'h3F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        next_frame_i,
    input  logic        enable_i,
    input  logic [1:0]  level_i,
    input  logic        obstacle_idle_i,
    output logic        spawn_o,
    output logic [1:0]  rand_o,
    output logic [15:0] spawn_count_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ARMED = 2'd2;

    logic [1:0]  state;
    logic [15:0] lfsr;
    logic [15:0] lfsr_step;
    logic [15:0] lfsr_nxt;
    logic [8:0]  frame_cnt;
    logic [8:0]  gap;
    logic [8:0]  gap_sum;
    logic [8:0]  gap_new;
    logic [10:0] eff_diff;
    logic [7:0]  eff;
    logic [9:0]  frame_inc;
    logic        accept;

    always_comb begin
        lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        lfsr_nxt  = (lfsr_step == 16'h0000) ? LFSR_SEED : lfsr_step;
    end

    // Subtraction done at 11 bits: bit 10 flags an underflow, which clamps to the floor.
    always_comb begin
        eff_diff = {3'b000, MIN_GAP} - ({3'b000, LEVEL_STEP} * {9'd0, level_i});
        if (eff_diff[10] || (eff_diff < {3'b000, GAP_FLOOR}))
            eff = GAP_FLOOR;
        else
            eff = eff_diff[7:0];
        gap_sum = {1'b0, eff} + {1'b0, lfsr[7:0] & GAP_MASK};
        gap_new = (gap_sum == 9'd0) ? 9'd1 : gap_sum;
    end

    always_comb begin
        frame_inc = {1'b0, frame_cnt} + 10'd1;
        accept    = next_frame_i && obstacle_idle_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            lfsr          <= LFSR_SEED;
            frame_cnt     <= 9'd0;
            gap           <= 9'd0;
            spawn_o       <= 1'b0;
            rand_o        <= 2'd0;
            spawn_count_o <= 16'd0;
        end else begin
            lfsr <= lfsr_nxt;
            if (!enable_i) begin
                state     <= ST_IDLE;
                spawn_o   <= 1'b0;
                frame_cnt <= 9'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state         <= ST_WAIT;
                        gap           <= gap_new;
                        frame_cnt     <= 9'd0;
                        spawn_count_o <= 16'd0;
                    end
                    ST_WAIT: begin
                        if (next_frame_i) begin
                            frame_cnt <= frame_inc[8:0];
                            if (frame_inc >= {1'b0, gap}) begin
                                state   <= ST_ARMED;
                                spawn_o <= 1'b1;
                                rand_o  <= lfsr[3:2];
                            end
                        end
                    end
                    ST_ARMED: begin
                        if (accept) begin
                            state     <= ST_WAIT;
                            spawn_o   <= 1'b0;
                            frame_cnt <= 9'd0;
                            gap       <= gap_new;
                            if (spawn_count_o != 16'hFFFF)
                                spawn_count_o <= spawn_count_o + 16'd1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        spawn_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Randomized bench: two spawner instances (default params, and a floor-clamping deterministic set)
// against a frame/gap reference model; spawn_o edges are scoreboarded through per-instance queues.
module tb_obstacle_spawner;

    logic        clk;
    logic        rst;
    logic        next_frame;
    logic        enable;
    logic [1:0]  level;
    logic        obs_idle;
    logic        spawn0, spawn1;
    logic [1:0]  rand0, rand1;
    logic [15:0] cnt0, cnt1;

    obstacle_spawner dut0 (
        .clk_i(clk), .rst_i(rst), .next_frame_i(next_frame), .enable_i(enable),
        .level_i(level), .obstacle_idle_i(obs_idle),
        .spawn_o(spawn0), .rand_o(rand0), .spawn_count_o(cnt0)
    );

    obstacle_spawner #(
        .MIN_GAP(8'd40), .LEVEL_STEP(8'd8), .GAP_FLOOR(8'd20), .GAP_MASK(8'h00)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .next_frame_i(next_frame), .enable_i(enable),
        .level_i(level), .obstacle_idle_i(obs_idle),
        .spawn_o(spawn1), .rand_o(rand1), .spawn_count_o(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int p_min   [2] = '{40, 40};
    int p_step  [2] = '{8, 8};
    int p_floor [2] = '{16, 20};
    int p_mask  [2] = '{63, 0};

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_ARMED = 2;

    typedef struct {
        bit rise;
        int cyc;
        int rnd;
        int cnt;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];

    logic [15:0] m_lfsr  [2];
    int          m_mode  [2];
    int          m_frames[2];
    int          m_gap   [2];
    int          m_rand  [2];
    int          m_count [2];
    int          m_spawns;

    int cyc;
    int n_total;
    int n_pass;
    bit mon_en;
    logic prev_sp [2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        if (n == 16'h0000) n = 16'hACE1;
        return n;
    endfunction

    function automatic int gap_of(input int d, input int lvl, input logic [15:0] lf);
        int e;
        e = p_min[d] - p_step[d] * lvl;
        if (e < p_floor[d]) e = p_floor[d];
        e = e + (int'(lf[7:0]) & p_mask[d]);
        if (e == 0) e = 1;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: frames waited against the gap, with the pending request as a flag.
    initial begin
        for (int d = 0; d < 2; d++) begin
            m_lfsr[d] = 16'hACE1; m_mode[d] = M_IDLE; m_frames[d] = 0;
            m_gap[d] = 0; m_rand[d] = 0; m_count[d] = 0;
        end
        cyc = 0;
        m_spawns = 0;
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            bit was_armed;
            bit now_armed;
            logic [15:0] lf;
            ev_t e;
            was_armed = (m_mode[d] == M_ARMED);
            lf = m_lfsr[d];
            if (rst) begin
                m_lfsr[d] = 16'hACE1; m_mode[d] = M_IDLE; m_frames[d] = 0;
                m_gap[d] = 0; m_rand[d] = 0; m_count[d] = 0;
            end else begin
                m_lfsr[d] = lfsr_next(lf);
                if (!enable) begin
                    m_mode[d] = M_IDLE;
                    m_frames[d] = 0;
                end else if (m_mode[d] == M_IDLE) begin
                    m_mode[d] = M_WAIT;
                    m_gap[d] = gap_of(d, int'(level), lf);
                    m_frames[d] = 0;
                    m_count[d] = 0;
                end else if (m_mode[d] == M_WAIT) begin
                    if (next_frame) begin
                        m_frames[d] = m_frames[d] + 1;
                        if (m_frames[d] >= m_gap[d]) begin
                            m_mode[d] = M_ARMED;
                            m_rand[d] = int'(lf[3:2]);
                        end
                    end
                end else if (next_frame && obs_idle) begin
                    m_mode[d] = M_WAIT;
                    m_frames[d] = 0;
                    m_gap[d] = gap_of(d, int'(level), lf);
                    if (m_count[d] < 65535) m_count[d] = m_count[d] + 1;
                    if (d == 0) m_spawns = m_spawns + 1;
                end
            end
            now_armed = (m_mode[d] == M_ARMED);
            if (now_armed != was_armed) begin
                e.rise = now_armed; e.cyc = cyc; e.rnd = m_rand[d]; e.cnt = m_count[d];
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
            end
        end
    end

    task automatic handle_edge(input int d, input logic sp, input logic [1:0] rnd, input logic [15:0] cnt);
        ev_t e;
        bit have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (!have) begin
            n_total++;
            $display("FAIL spawn_edge_unexpected dut%0d: actual spawn_o=%0b required no edge (cycle %0d)", d, sp, cyc);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("spawn_edge_dir%0d", d), {31'd0, sp}, {31'd0, e.rise});
            check($sformatf("spawn_edge_cycle%0d", d), cyc, e.cyc);
            if (e.rise) check($sformatf("rand_at_rise%0d", d), {30'd0, rnd}, e.rnd);
            else check($sformatf("count_at_fall%0d", d), {16'd0, cnt}, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (spawn0 !== prev_sp[0]) begin
                handle_edge(0, spawn0, rand0, cnt0);
                prev_sp[0] = spawn0;
            end
            if (spawn1 !== prev_sp[1]) begin
                handle_edge(1, spawn1, rand1, cnt1);
                prev_sp[1] = spawn1;
            end
            check("rand_o_0", {30'd0, rand0}, m_rand[0]);
            check("rand_o_1", {30'd0, rand1}, m_rand[1]);
            check("spawn_count_0", {16'd0, cnt0}, m_count[0]);
            check("spawn_count_1", {16'd0, cnt1}, m_count[1]);
            check("lfsr_0", {16'd0, dut0.lfsr}, {16'd0, m_lfsr[0]});
        end
    end

    initial begin
        int frame_timer;
        int en_off;
        int waited;
        n_total = 0; n_pass = 0; mon_en = 1'b0;
        prev_sp[0] = 1'b0; prev_sp[1] = 1'b0;
        rst = 1'b1; next_frame = 1'b0; enable = 1'b0; level = 2'd0; obs_idle = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_spawn0", {31'd0, spawn0}, 0);
        check("reset_rand0", {30'd0, rand0}, 0);
        check("reset_count0", {16'd0, cnt0}, 0);
        check("reset_spawn1", {31'd0, spawn1}, 0);
        check("reset_lfsr", {16'd0, dut0.lfsr}, 32'h0000ACE1);
        rst = 1'b0;
        enable = 1'b1;
        mon_en = 1'b1;
        frame_timer = 2;
        en_off = 0;
        for (int c = 0; c < 14000; c++) begin
            @(negedge clk);
            next_frame = (frame_timer == 0);
            frame_timer = next_frame ? $urandom_range(4, 1) : frame_timer - 1;
            if (en_off > 0) en_off = en_off - 1;
            else if ($urandom_range(2499, 0) == 0) en_off = $urandom_range(6, 1);
            enable = (en_off == 0);
            obs_idle = ($urandom_range(3, 0) != 0);
            if ($urandom_range(299, 0) == 0) level = 2'($urandom);
            rst = ($urandom_range(9999, 0) == 0);
        end
        // Force an enable drop while a request is pending, then re-enable.
        rst = 1'b0; enable = 1'b1; obs_idle = 1'b0; next_frame = 1'b0;
        waited = 0;
        while (m_mode[0] != M_ARMED && waited < 3000) begin
            @(negedge clk);
            next_frame = (waited % 3 == 0);
            waited++;
        end
        if (m_mode[0] != M_ARMED) begin
            n_total++;
            $display("FAIL armed_timeout: actual not armed after %0d cycles required armed", waited);
        end
        @(negedge clk);
        next_frame = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("enable_low_spawn", {31'd0, spawn0}, 0);
        enable = 1'b1; obs_idle = 1'b1;
        repeat (3) @(negedge clk);
        check("reenable_count", {16'd0, cnt0}, 0);
        repeat (4) @(negedge clk);
        check("events_left0", q0.size(), 0);
        check("events_left1", q1.size(), 0);
        if (m_spawns < 5) begin
            n_total++;
            $display("FAIL too_few_spawns: actual %0d required at least 5", m_spawns);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
